turn_dice_ctrl: RTL and testbench

// - Upstream front end of the snake-and-ladder core: debounces the roll button, runs the dice
//   (1..6) while the button is held, freezes the value on release and issues one commit strobe.
// - Alternates the active player after each committed move. Stops all play once game_over is

---
 rtl/turn_dice_ctrl.sv | 120 ++++++++++++
 tb/tb_turn_dice_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/turn_dice_ctrl.sv
// Roll-button front end: debounce, live dice 1..6, freeze on release, settle, one commit strobe.
// Optional macro EXTRA_TURN_ON_SIX_EN: a committed six keeps the same player for another roll.
module turn_dice_ctrl #(
  parameter int DEB_CYC    = 16,
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic             game_over,
  output logic [2:0]       dice,
  output logic             dice_valid,
  output logic             commit,
  output logic             player,
  output logic             rolling,
  output logic [CNT_W-1:0] turn_cnt
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYC - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {IDLE, ROLLING, SETTLE, COMMIT, DONE} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             btn_q, btn_d;
  logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
  logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [2:0]       dice_q, dice_d;
  logic             player_q, player_d;
  logic [CNT_W-1:0] turn_q, turn_d;
  logic             btn_accept, btn_rise, btn_fall;

  // The FSM reacts on the same edge the new debounced level is accepted.
  always_comb begin
    btn_accept = 1'b0;
    btn_d      = btn_q;
    deb_cnt_d  = '0;
    if (sync2_q != btn_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        btn_accept = 1'b1;
        btn_d      = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
    btn_rise = btn_accept & sync2_q;
    btn_fall = btn_accept & ~sync2_q;
  end

  always_comb begin
    state_d      = state_q;
    dice_d       = dice_q;
    player_d     = player_q;
    turn_d       = turn_q;
    settle_cnt_d = '0;
    case (state_q)
      IDLE: begin
        if (game_over)     state_d = DONE;
        else if (btn_rise) state_d = ROLLING;
      end
      ROLLING: begin
        if (game_over)     state_d = DONE;
        else if (btn_fall) state_d = SETTLE;
        else               dice_d  = (dice_q == 3'd6) ? 3'd1 : dice_q + 3'd1;
      end
      SETTLE: begin
        if (game_over)                     state_d = DONE;
        else if (settle_cnt_q == SETTLE_LAST) state_d = COMMIT;
        else                               settle_cnt_d = settle_cnt_q + SW'(1);
      end
      COMMIT: begin
`ifdef EXTRA_TURN_ON_SIX_EN
        player_d = (dice_q == 3'd6) ? player_q : ~player_q;
`else
        player_d = ~player_q;
`endif
        turn_d  = (turn_q == '1) ? turn_q : turn_q + CNT_W'(1);
        state_d = game_over ? DONE : IDLE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      btn_q        <= 1'b0;
      deb_cnt_q    <= '0;
      settle_cnt_q <= '0;
      state_q      <= IDLE;
      dice_q       <= 3'd1;
      player_q     <= 1'b0;
      turn_q       <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      btn_q        <= btn_d;
      deb_cnt_q    <= deb_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      state_q      <= state_d;
      dice_q       <= dice_d;
      player_q     <= player_d;
      turn_q       <= turn_d;
    end
  end

  assign dice       = dice_q;
  assign player     = player_q;
  assign turn_cnt   = turn_q;
  assign rolling    = (state_q == ROLLING);
  assign dice_valid = (state_q == SETTLE) || (state_q == COMMIT);
  assign commit     = (state_q == COMMIT);

endmodule

// File: tb/tb_turn_dice_ctrl.sv
// Self-checking bench for turn_dice_ctrl: randomized button holds against an arithmetic timing model.
module tb_turn_dice_ctrl;
  localparam int DEB  = 16;
  localparam int SET  = 4;
  localparam int CW   = 3;
  localparam int TMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, btn_raw, game_over;
  logic [2:0]    dice;
  logic          dice_valid, commit, player, rolling;
  logic [CW-1:0] turn_cnt;

  int checks = 0;
  int errors = 0;
  int m_dice, m_player, m_turn;

  turn_dice_ctrl #(.DEB_CYC(DEB), .SETTLE_CYC(SET), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .game_over(game_over),
    .dice(dice), .dice_valid(dice_valid), .commit(commit), .player(player),
    .rolling(rolling), .turn_cnt(turn_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // dice advanced n steps through the 1..6 ring
  function automatic int adv(input int d, input int n);
    return ((d - 1 + n) % 6) + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int e_dice, input int e_valid,
                           input int e_commit, input int e_player, input int e_roll,
                           input int e_turn);
    check({tag, ".dice"},     32'(dice),       e_dice);
    check({tag, ".valid"},    32'(dice_valid), e_valid);
    check({tag, ".commit"},   32'(commit),     e_commit);
    check({tag, ".player"},   32'(player),     e_player);
    check({tag, ".rolling"},  32'(rolling),    e_roll);
    check({tag, ".turn_cnt"}, 32'(turn_cnt),   e_turn);
  endtask

  task automatic check_idle(input string tag);
    check_all(tag, m_dice, 0, 0, m_player, 0, m_turn);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    game_over = 1'b0;
    btn_raw = 1'b0;
    repeat (3) tick();
    m_dice = 1; m_player = 0; m_turn = 0;
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("post_reset");
  endtask

  // mode 0: normal move, 1: game_over raised during settle, 2: reset just before commit
  task automatic do_move(input int h, input int mode);
    int a, f, c, n, frozen, np, nt, go_at, rst_at;
    a      = 2 + DEB;
    f      = h + 2 + DEB;
    c      = f + SET;
    n      = c + 3;
    frozen = adv(m_dice, h - 1);
`ifdef EXTRA_TURN_ON_SIX_EN
    np = (frozen == 6) ? m_player : 1 - m_player;
`else
    np = 1 - m_player;
`endif
    nt     = (m_turn + 1 > TMAX) ? TMAX : m_turn + 1;
    go_at  = (mode == 1) ? f + 1 : 0;
    rst_at = (mode == 2) ? c - 1 : 0;
    btn_raw = 1'b1;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (rst_at > 0 && k > rst_at)
        check_all("mv_rst", 1, 0, 0, 0, 0, 0);
      else if (go_at > 0 && k > go_at)
        check_all("mv_abort", frozen, 0, 0, m_player, 0, m_turn);
      else
        check_all("mv",
                  (k < a) ? m_dice : ((k < f) ? adv(m_dice, k - a) : frozen),
                  (k >= f && k <= c) ? 1 : 0,
                  (k == c) ? 1 : 0,
                  (k > c) ? np : m_player,
                  (k >= a && k < f) ? 1 : 0,
                  (k > c) ? nt : m_turn);
      check("dice_range", 32'((dice >= 3'd1) && (dice <= 3'd6)), 1);
      if (k == h)      btn_raw = 1'b0;
      if (k == go_at)  game_over = 1'b1;
      if (k == rst_at) rst = 1'b1;
      if (rst_at > 0 && k == rst_at + 3) rst = 1'b0;
    end
    if (mode == 2) begin
      m_dice = 1; m_player = 0; m_turn = 0;
    end else if (mode == 1) begin
      m_dice = frozen;
    end else begin
      m_dice = frozen; m_player = np; m_turn = nt;
    end
  endtask

  // chooses a hold length whose frozen dice equals target
  task automatic move_to(input int target);
    int h;
    h = DEB + 6 * $urandom_range(0, 3);
    while (adv(m_dice, h - 1) != target) h++;
    do_move(h, 0);
  endtask

  task automatic press_no_effect(input string tag);
    btn_raw = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      check_idle(tag);
      if (k == 30) btn_raw = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; btn_raw = 1'b0; game_over = 1'b0;
    do_reset();

    // bounce faster than the debounce window must never start a roll
    for (int k = 0; k < 100; k++) begin
      if (k % 5 == 0) btn_raw = ~btn_raw;
      tick();
      check_idle("bounce");
    end
    btn_raw = 1'b0;
    repeat (30) begin
      tick();
      check_idle("bounce_quiet");
    end

    move_to(6);
    move_to(3);
    do_move(200, 0);
    repeat (8) do_move(DEB + $urandom_range(0, 30), 0);

    do_move(DEB + $urandom_range(0, 20), 2);
    do_move(DEB + $urandom_range(0, 20), 0);

    do_move(DEB + $urandom_range(0, 20), 1);
    press_no_effect("done_press");
    do_reset();
    do_move(DEB + $urandom_range(0, 20), 0);

    game_over = 1'b1;
    repeat (2) tick();
    press_no_effect("idle_gameover");
    do_reset();
    do_move(DEB + $urandom_range(0, 20), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
